// File: rtl/ber_checker_if.sv
// ber_checker_if: serial bit handshake between the error channel and the checker
interface ber_checker_if;
  logic valid_in;
  logic data_in;
  logic ready_in;
  modport master (output valid_in, output data_in, input ready_in);
  modport slave (input valid_in, input data_in, output ready_in);
endinterface

// File: rtl/ber_checker.sv
// ber_checker: PRBS6 bit-error-rate checker with lock acquisition, per-block error reports and saturating totals
module ber_checker #(
  parameter int LOCK_LEN = 16,
  parameter int LOSS_THR = 8
) (
  input  logic              clk,
  input  logic              rst,
  ber_checker_if.slave      bus,
  input  logic              clear,
  output logic              locked,
  output logic              block_valid,
  output logic [5:0]        block_errs,
  output logic [31:0]       total_bits,
  output logic [31:0]       total_errs
);
  localparam logic [1:0] SEED   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  logic [1:0]  r_state;
  logic [5:0]  r_s;
  logic [2:0]  r_seed_cnt;
  logic [5:0]  r_match_cnt;
  logic [5:0]  r_bit_idx;
  logic [5:0]  r_blk_err;
  logic        r_block_valid;
  logic [5:0]  r_block_errs;
  logic [31:0] r_total_bits;
  logic [31:0] r_total_errs;
  logic        w_acc;
  logic        w_exp;
  logic        w_mis;
  logic [5:0]  w_s_in;
  logic [5:0]  w_blk_final;
  logic [5:0]  w_match_next;
  logic        w_last;
  logic        w_count;
  assign bus.ready_in  = !rst;
  assign w_acc         = bus.valid_in && !rst;
  assign w_exp         = r_s[5] ^ r_s[4];
  assign w_mis         = bus.data_in != w_exp;
  assign w_s_in        = {r_s[4:0], bus.data_in};
  assign w_blk_final   = r_blk_err + {5'd0, w_mis};
  assign w_match_next  = r_match_cnt + 6'd1;
  assign w_last        = r_bit_idx == 6'd62;
  assign w_count       = w_acc && r_state == LOCKED;
  assign locked        = r_state == LOCKED;
  assign block_valid   = r_block_valid;
  assign block_errs    = r_block_errs;
  assign total_bits    = r_total_bits;
  assign total_errs    = r_total_errs;
  // Statistics totals: saturating counts of locked bits and errors; clear overrides any increment
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_total_bits <= '0;
      r_total_errs <= '0;
    end else if (w_count) begin
      r_total_bits <= r_total_bits + {31'd0, ~&r_total_bits};
      r_total_errs <= r_total_errs + {31'd0, w_mis & ~&r_total_errs};
    end
  end
  // Lock FSM, reference state, block bookkeeping and the one-cycle block report
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= SEED;
      r_s           <= '0;
      r_seed_cnt    <= '0;
      r_match_cnt   <= '0;
      r_bit_idx     <= '0;
      r_blk_err     <= '0;
      r_block_valid <= 1'b0;
      r_block_errs  <= '0;
    end else begin
      r_block_valid <= 1'b0;
      if (w_acc) begin
        if (r_state == LOCKED) begin
          r_s       <= {r_s[4:0], w_exp};
          r_bit_idx <= w_last ? 6'd0 : r_bit_idx + 6'd1;
          r_blk_err <= w_last ? 6'd0 : w_blk_final;
          if (w_last) begin
            r_block_valid <= 1'b1;
            r_block_errs  <= w_blk_final;
            if (w_blk_final > 6'(LOSS_THR)) begin
              r_state     <= SEED;
              r_seed_cnt  <= '0;
              r_match_cnt <= '0;
            end
          end
        end else if (r_state == VERIFY) begin
          r_s         <= w_s_in;
          r_match_cnt <= w_mis ? 6'd0 : w_match_next;
          if (!w_mis && w_match_next == 6'(LOCK_LEN)) begin
            r_state   <= LOCKED;
            r_bit_idx <= '0;
            r_blk_err <= '0;
          end
        end else begin
          r_s        <= w_s_in;
          r_seed_cnt <= r_seed_cnt == 3'd5 ? 3'd0 : r_seed_cnt + 3'd1;
          if (r_seed_cnt == 3'd5 && w_s_in != 6'd0) begin
            r_state     <= VERIFY;
            r_match_cnt <= '0;
          end else begin
            r_state <= SEED;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker: scoreboard bench for the PRBS6 BER checker
module tb_ber_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        locked;
  logic        block_valid;
  logic [5:0]  block_errs;
  logic [31:0] total_bits;
  logic [31:0] total_errs;
  ber_checker_if bus ();
  ber_checker #(.LOCK_LEN(16), .LOSS_THR(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clear(clear), .locked(locked),
    .block_valid(block_valid), .block_errs(block_errs),
    .total_bits(total_bits), .total_errs(total_errs)
  );
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  int exp_bits = 0;
  int exp_errs = 0;
  int exp_e;
  int exp_q[$];
  logic [5:0] g = 6'b000001;
  logic gap = 1'b0;
  // Block-report monitor: every pulse must match the oldest expected block count
  always @(negedge clk) begin
    if (block_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got block_errs=%0d, expected no block_valid", block_errs);
      end else begin
        exp_e = exp_q.pop_front();
        if (block_errs !== 6'(exp_e)) begin
          n_fail++;
          $display("FAIL block_errs: got %0d, expected %0d", block_errs, exp_e);
        end
      end
    end
  end
  task automatic drive_bit(input logic err, input logic clr);
    logic b;
    b = g[5] ^ g[4];
    g = {g[4:0], b};
    bus.valid_in = 1'b1;
    bus.data_in = b ^ err;
    clear = clr;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    clear = 1'b0;
    if (gap) begin
      bus.data_in = ~bus.data_in;
      @(posedge clk); #1;
    end
  endtask
  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
  endtask
  task automatic send_block(input logic [62:0] mask, input int clr_pos);
    for (int i = 0; i < 63; i++) begin
      if (i == 62) exp_q.push_back($countones(mask));
      if (i == clr_pos) begin
        exp_bits = 0;
        exp_errs = 0;
      end else begin
        exp_bits++;
        exp_errs += int'(mask[i]);
      end
      drive_bit(mask[i], i == clr_pos);
    end
  endtask
  task automatic check_totals(input string tag);
    n_tests++;
    if (total_bits !== 32'(exp_bits)) begin
      n_fail++;
      $display("FAIL %s total_bits: got %0d, expected %0d", tag, total_bits, exp_bits);
    end
    n_tests++;
    if (total_errs !== 32'(exp_errs)) begin
      n_fail++;
      $display("FAIL %s total_errs: got %0d, expected %0d", tag, total_errs, exp_errs);
    end
  endtask
  task automatic check_lock(input string tag);
    send_clean(21);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL %s lock_early: got locked=%b, expected 0", tag, locked);
    end
    send_clean(1);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL %s lock_point: got locked=%b, expected 1", tag, locked);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if ({bus.ready_in, locked, block_valid, block_errs, total_bits, total_errs} !== 73'd0) begin
      n_fail++;
      $display("FAIL %s: got ready=%b locked=%b bv=%b be=%0d tb=%0d te=%0d, expected all 0",
               tag, bus.ready_in, locked, block_valid, block_errs, total_bits, total_errs);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;
    exp_bits = 0;
    exp_errs = 0;
    #1;
    n_tests++;
    if (bus.ready_in !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b, expected 1", bus.ready_in);
    end
  endtask
  task automatic test_lock();
    check_lock("clean");
    send_block('0, -1);
    send_block('0, -1);
    check_totals("clean_blocks");
  endtask
  task automatic test_errors();
    send_block((63'd1 << 5) | (63'd1 << 40), -1);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL two_err_locked: got %b, expected 1", locked);
    end
    check_totals("two_err");
    send_block('0, -1);
  endtask
  task automatic test_loss();
    send_block(63'hFF, -1);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL at_threshold_locked: got %b, expected 1", locked);
    end
    send_block(63'h1FF << 20, -1);
    n_tests++;
    if ({block_valid, locked} !== 2'b10) begin
      n_fail++;
      $display("FAIL loss_drop: got block_valid=%b locked=%b, expected 1 0", block_valid, locked);
    end
    check_lock("relock");
    send_block('0, -1);
    check_totals("after_relock");
  endtask
  task automatic test_clear();
    send_block((63'd1 << 10) | (63'd1 << 20), 10);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_locked: got %b, expected 1", locked);
    end
    check_totals("clear");
  endtask
  task automatic test_rst_mid();
    send_clean(30);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_mid_block");
    rst = 1'b0;
    exp_bits = 0;
    exp_errs = 0;
  endtask
  task automatic test_all_zero();
    logic seen;
    seen = 1'b0;
    bus.data_in = 1'b0;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      seen |= locked;
    end
    bus.valid_in = 1'b0;
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL all_zero: got locked=1 at some point, expected 0 throughout");
    end
    check_totals("all_zero");
  endtask
  task automatic test_valid_toggle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_bits = 0;
    exp_errs = 0;
    gap = 1'b1;
    check_lock("toggle");
    send_block('0, -1);
    send_block('0, -1);
    gap = 1'b0;
    check_totals("toggle");
  endtask
  initial begin
    bus.valid_in = 1'b0;
    bus.data_in = 1'b0;
    test_reset();
    test_lock();
    test_errors();
    test_loss();
    test_clear();
    test_rst_mid();
    test_all_zero();
    test_valid_toggle();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: got %0d unreported blocks, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter LOCK_LEN, default 16: consecutive matching bits required to declare lock (range 1..63).
REQ-002 Parameter LOSS_THR, default 8: per-block error count above which lock is dropped (range 0..63).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 valid_in  input  1  data_in carries a valid bit this cycle.
REQ-006 data_in  input  1  received serial bit from the error channel.
REQ-007 ready_in  output  1  checker accepts a bit this cycle; a bit is accepted when valid_in && ready_in.
REQ-008 clear  input  1  synchronous clear of statistics counters only; lock state is unaffected.
REQ-009 locked  output  1  high while the checker is in state LOCKED.
REQ-010 block_valid  output  1  one-cycle pulse at the end of each 63-bit block checked while locked.
REQ-011 block_errs  output  6  bit errors in the block just completed; valid when block_valid is high, held otherwise.
REQ-012 total_bits  output  32  bits checked while locked; saturates at 2^32-1.
REQ-013 total_errs  output  32  errors counted while locked; saturates at 2^32-1.

Function
REQ-014 The reference sequence SHALL be PRBS6, polynomial x^6+x^5+1, period 63, 6-bit state s; expected bit e = s[5]^s[4].
REQ-015 ready_in SHALL be 0 in the cycle rst is high and 1 in every other cycle; the block never back-pressures.
REQ-016 States SHALL be SEED, VERIFY and LOCKED; on an unaccepted cycle, state, s and all counters hold.
REQ-017 SEED: each accepted bit shifts in as s <= {s[4:0], data_in}; after 6 accepted bits, go to VERIFY if s != 0, else restart the 6-bit collection.
REQ-018 VERIFY: each accepted bit is compared with e, then s <= {s[4:0], data_in}; a match increments match_cnt; a mismatch clears match_cnt.
REQ-019 VERIFY: when match_cnt reaches LOCK_LEN, go to LOCKED next cycle with bit_idx = 0 and blk_err = 0.
REQ-020 LOCKED: s SHALL free-run as s <= {s[4:0], e}, so received errors never corrupt the reference.
REQ-021 LOCKED: each accepted bit increments total_bits; a mismatch (data_in != e) increments blk_err and total_errs.
REQ-022 LOCKED: bit_idx counts 0..62 and wraps; the bit accepted at bit_idx == 62 ends a block.
REQ-023 Block end: next cycle block_valid = 1 and block_errs = blk_err including the final bit; blk_err restarts at 0 for the next bit (latency 1 cycle).
REQ-024 Block end with final count > LOSS_THR: block_valid still pulses, then state goes to SEED with match_cnt = 0 and locked falls in the same cycle as the pulse.
REQ-025 clear concurrent with an accepted mismatch: the counters SHALL read 0 afterwards (clear wins); blk_err is not affected by clear.
REQ-026 Saturation: total_bits and total_errs hold at all-ones; they never wrap.
REQ-027 Accepted bits in SEED and VERIFY SHALL not update total_bits, total_errs or blk_err.

Reset
REQ-028 While rst is high: state = SEED, s = 0, match_cnt = 0, bit_idx = 0, blk_err = 0, locked = 0, block_valid = 0, block_errs = 0, total_bits = 0, total_errs = 0, ready_in = 0.
REQ-029 rst asserted mid-block SHALL discard the partial block with no block_valid pulse.

Verification
REQ-030 Clean PRBS6 stream, valid_in always 1, LOCK_LEN = 16 -> locked rises after the 22nd accepted bit; every 63 bits after lock, block_valid pulses with block_errs = 0.
REQ-031 Locked, one bit inverted at block positions 5 and 40 -> that block reports block_errs = 2, total_errs += 2, locked stays 1; the following block reports 0.
REQ-032 Locked, 9 errors in one block, LOSS_THR = 8 -> block_errs = 9 pulse, locked falls, relock after 22 further clean bits.
REQ-033 All-zero input stream -> state never leaves SEED and locked stays 0.
REQ-034 valid_in toggling 1/0 every cycle on a clean stream -> same lock point and block boundaries, counted in accepted bits; no errors.
REQ-035 clear pulsed on an error-bit cycle -> total_errs = 0 and total_bits = 0 next cycle, locked unchanged; rst mid-block -> all outputs per REQ-028 and no block_valid pulse.
